// File: rtl/clkdiv_frac_if.sv
// Bundle of per-channel control inputs and enable outputs for clkdiv_frac.
// tick_cnt exists only when CLKDIV_CNT_EN is defined.
interface clkdiv_frac_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       active;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] freq;
  logic [CHANNELS*WIDTH-1:0] fref;
  logic [CHANNELS-1:0]       hold;
`ifdef CLKDIV_CNT_EN
  logic [CHANNELS*32-1:0]    tick_cnt;

  modport master (output active, load, mode, freq, fref, input hold, tick_cnt);
  modport slave  (input active, load, mode, freq, fref, output hold, tick_cnt);
`else
  modport master (output active, load, mode, freq, fref, input hold);
  modport slave  (input active, load, mode, freq, fref, output hold);
`endif
endinterface

// File: rtl/clkdiv_frac.sv
// Per-channel run enable: hold=1 for freq of every fref clocks, spread or burst; registered, 1-cycle latency, no backpressure.
// Define CLKDIV_CNT_EN to add a 32-bit run-cycle counter (tick_cnt) per channel.
module clkdiv_frac #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic          clock,
  input  logic          reset,
  clkdiv_frac_if.slave  bus
);

  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic [CHANNELS-1:0] w_hold;
`ifdef CLKDIV_CNT_EN
  logic [CHANNELS*32-1:0] w_tick;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_freq;
    logic [WIDTH-1:0] r_fref;
    logic             r_mode;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_hold;

    logic [WIDTH-1:0] w_freq_in;
    logic [WIDTH-1:0] w_fref_in;
    logic [WIDTH:0]   w_sum;
    logic             w_hold_nxt;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign w_freq_in = bus.freq[c*WIDTH +: WIDTH];
    assign w_fref_in = bus.fref[c*WIDTH +: WIDTH];
    // acc stays below fref, so acc+freq never exceeds WIDTH+1 bits
    assign w_sum     = r_acc + {1'b0, r_freq};

    always_comb begin
      w_hold_nxt = 1'b1;
      w_acc_nxt  = r_acc;
      w_cnt_nxt  = r_cnt;
      if (r_fref == '0) begin
        w_hold_nxt = 1'b1;
      end else if (r_freq >= r_fref) begin
        w_hold_nxt = 1'b1;
        w_acc_nxt  = '0;
        w_cnt_nxt  = '0;
      end else if (r_freq == '0) begin
        w_hold_nxt = 1'b0;
      end else if (r_mode) begin
        if (w_sum >= {1'b0, r_fref}) begin
          w_hold_nxt = 1'b1;
          w_acc_nxt  = w_sum - {1'b0, r_fref};
        end else begin
          w_hold_nxt = 1'b0;
          w_acc_nxt  = w_sum;
        end
      end else begin
        w_hold_nxt = (r_cnt < r_freq);
        w_cnt_nxt  = (r_cnt == r_fref - LP_ONE) ? '0 : r_cnt + LP_ONE;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_freq <= LP_ONE;
        r_fref <= LP_ONE;
        r_mode <= 1'b1;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_hold <= 1'b1;
      end else if (bus.load[c]) begin
        r_freq <= w_freq_in;
        r_fref <= w_fref_in;
        r_mode <= bus.mode[c];
        r_acc  <= '0;
        r_cnt  <= '0;
        r_hold <= 1'b1;
      end else if (bus.active[c]) begin
        r_hold <= 1'b1;
      end else begin
        r_hold <= w_hold_nxt;
        r_acc  <= w_acc_nxt;
        r_cnt  <= w_cnt_nxt;
      end
    end

    assign w_hold[c] = r_hold;

`ifdef CLKDIV_CNT_EN
    logic [31:0] r_tick;

    // counts the registered enable, so forced highs from load/active are included
    always_ff @(posedge clock) begin
      if (reset || bus.load[c]) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + 32'(r_hold);
      end
    end

    assign w_tick[c*32 +: 32] = r_tick;
`endif
  end

  assign bus.hold = w_hold;
`ifdef CLKDIV_CNT_EN
  assign bus.tick_cnt = w_tick;
`endif

endmodule

// File: tb/tb_clkdiv_frac.sv
// Scoreboard bench for clkdiv_frac: driver pushes model expectations, monitor pops and compares each cycle.
module tb_clkdiv_frac;
  localparam int CH = 2;
  localparam int W  = 8;

  typedef struct packed {
    logic [CH-1:0]    hold;
    logic [CH*32-1:0] tick;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  clkdiv_frac_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  clkdiv_frac #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus state (held between cycles; load strobes auto-clear)
  logic              s_rst;
  logic [CH-1:0]     s_act, s_ld, s_md;
  logic [CH*W-1:0]   s_fq, s_fr;

  // reference model: counting index n since last load, rates, expected outputs
  longint      m_freq [CH];
  longint      m_fref [CH];
  bit          m_mode [CH];
  longint      m_n    [CH];
  bit          m_hold [CH];
  logic [31:0] m_tick [CH];

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic bit ideal_hold(input int c);
    longint n, f, r;
    n = m_n[c];
    f = m_freq[c];
    r = m_fref[c];
    if (m_mode[c])
      // run cycle whenever floor(n*f/r) steps up: even spacing, f per r
      return ((n * f) / r) != (((n - 1) * f) / r);
    else
      return ((n - 1) % r) < f;
  endfunction

  task automatic model_step();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      if (s_rst) begin
        m_freq[c] = 1; m_fref[c] = 1; m_mode[c] = 1'b1;
        m_n[c] = 0; m_hold[c] = 1'b1; m_tick[c] = '0;
      end else if (s_ld[c]) begin
        m_freq[c] = longint'(s_fq[c*W +: W]);
        m_fref[c] = longint'(s_fr[c*W +: W]);
        m_mode[c] = s_md[c];
        m_n[c] = 0; m_hold[c] = 1'b1; m_tick[c] = '0;
      end else begin
        m_tick[c] = m_tick[c] + 32'(m_hold[c]);
        if (s_act[c])                  m_hold[c] = 1'b1;
        else if (m_fref[c] == 0)       m_hold[c] = 1'b1;
        else if (m_freq[c] >= m_fref[c]) m_hold[c] = 1'b1;
        else if (m_freq[c] == 0)       m_hold[c] = 1'b0;
        else begin
          m_n[c] = m_n[c] + 1;
          m_hold[c] = ideal_hold(c);
        end
      end
      e.hold[c] = m_hold[c];
      e.tick[c*32 +: 32] = m_tick[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clock);
    reset      = s_rst;
    bus.active = s_act;
    bus.load   = s_ld;
    bus.mode   = s_md;
    bus.freq   = s_fq;
    bus.fref   = s_fr;
    model_step();
    s_ld  = '0;
    s_rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_ch(input int c, input logic md, input int f, input int r);
    s_md[c] = md;
    s_fq[c*W +: W] = W'(f);
    s_fr[c*W +: W] = W'(r);
    s_ld[c] = 1'b1;
  endtask

  // monitor: DUT presents hold every cycle; compare against oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.hold !== e.hold) begin
          n_bad++;
          $display("FAIL hold t=%0t actual=%b required=%b", $time, bus.hold, e.hold);
        end
`ifdef CLKDIV_CNT_EN
        n_cmp++;
        if (bus.tick_cnt !== e.tick) begin
          n_bad++;
          $display("FAIL tick_cnt t=%0t actual=%h required=%h", $time, bus.tick_cnt, e.tick);
        end
`endif
      end
    end
  end

  initial begin
    int wait_cyc;
    s_rst = 1'b1; s_act = '0; s_ld = '0; s_md = '0; s_fq = '0; s_fr = '0;
    bus.active = '0; bus.load = '0; bus.mode = '0; bus.freq = '0; bus.fref = '0;

    // reset state, then reset-value (full rate) operation
    s_rst = 1'b1; cyc();
    s_rst = 1'b1; cyc();
    run(5);

    // spread 3/8 on ch0, burst 125/250 on ch1
    set_ch(0, 1'b1, 3, 8);
    set_ch(1, 1'b0, 125, 250);
    run(81);

    // burst vs spread at 125/250 on ch0 while ch1 keeps running
    set_ch(0, 1'b0, 125, 250); run(260);
    set_ch(0, 1'b1, 125, 250); run(20);

    // degenerate rates
    set_ch(0, 1'b1, 9, 8);  run(10);
    set_ch(0, 1'b1, 0, 8);  run(10);
    set_ch(0, 1'b0, 0, 8);  run(10);
    set_ch(0, 1'b1, 5, 0);  run(10);
    set_ch(0, 1'b0, 8, 8);  run(10);
    set_ch(0, 1'b0, 255, 254); run(10);

    // active freeze mid-window, then resume from frozen phase
    set_ch(0, 1'b1, 3, 8); run(5);
    s_act[0] = 1'b1; run(10);
    s_act[0] = 1'b0; run(20);
    set_ch(0, 1'b0, 3, 7); run(4);
    s_act[0] = 1'b1; run(10);
    s_act[0] = 1'b0; run(15);

    // load held high for several cycles, then mid-window reload
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 5, 13); cyc();
    end
    run(6);
    set_ch(0, 1'b1, 2, 9); run(12);

    // reset pulse mid-pattern
    s_rst = 1'b1; cyc();
    run(10);

    // randomized traffic; unloaded channels see changing freq/fref that must be ignored
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        s_fq[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
        s_fr[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
        s_md[c]  = 1'($urandom);
        s_ld[c]  = ($urandom_range(0, 24) == 0);
        s_act[c] = ($urandom_range(0, 9) == 0);
      end
      s_rst = ($urandom_range(0, 249) == 0);
      cyc();
    end
    s_act = '0;
    run(5);

    // drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
